// File: rtl/bin2therm_pipeline_if.sv
// Sample-side signal bundle for the binary-to-thermometer encoder.
// The master drives codes in and receives thermometer words.
// The slave is the encoder itself.
interface bin2therm_pipeline_if #(
    parameter int b = 8
);
    logic              enable;
    logic              valid;
    logic [b-1:0]      bin;
    logic              valid_out;
    logic [(1<<b)-1:0] thermo;

    modport master (
        output enable,
        output valid,
        output bin,
        input  valid_out,
        input  thermo
    );

    modport slave (
        input  enable,
        input  valid,
        input  bin,
        output valid_out,
        output thermo
    );
endinterface

// File: rtl/bin2therm_pipeline.sv
// Pipelined binary-to-thermometer encoder.
// Stage 0 registers the input code. Stages 1..b each resolve one code bit, MSB first.
// When a stage's bit is set, it ORs a block of ones into the partial word.
// The block sits directly above the region already filled by the higher bits.
// Stage b is the output register. It zeroes the word for invalid samples.
module bin2therm_pipeline #(
    parameter int b = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    bin2therm_pipeline_if.slave  bus
);
    localparam int N = 1 << b;

    // Per-stage views of the carried code, valid bit and partial word.
    // Index k is the content of stage k. The output stage needs no code.
    logic [b-1:0] code_pipe  [0:b-1];
    logic         valid_pipe [0:b];
    logic [N-1:0] word_pipe  [0:b];

    logic [b-1:0] code_in_reg;
    logic         valid_in_reg;

    // Input register (stage 0): capture the code and qualifier on enabled edges.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            code_in_reg  <= '0;
            valid_in_reg <= 1'b0;
        end else if (bus.enable) begin
            code_in_reg  <= bus.bin;
            valid_in_reg <= bus.valid;
        end
    end

    assign code_pipe[0]  = code_in_reg;
    assign valid_pipe[0] = valid_in_reg;
    assign word_pipe[0]  = '0;

    genvar gi;
    generate
        for (gi = 1; gi <= b; gi++) begin : g_stage
            // Bit index resolved here, and the size of the block of ones it represents.
            localparam int BI = b - gi;
            localparam int W  = 1 << BI;
            // W ones in the low bits. W never exceeds N/2, so the zero pad is never empty.
            localparam logic [N-1:0] BLOCK = {{(N-W){1'b0}}, {W{1'b1}}};
            localparam bit LAST = (gi == b);

            logic [b:0]   base;
            logic [N-1:0] word_next;
            logic [N-1:0] word_reg;
            logic         valid_reg;

            // Base of the fill is the value of the code bits above BI.
            // Those bits are exactly what earlier stages have already filled.
            always_comb begin
                base      = ({1'b0, code_pipe[gi-1]} >> (BI + 1)) << (BI + 1);
                word_next = word_pipe[gi-1];
                if (code_pipe[gi-1][BI]) begin
                    word_next = word_pipe[gi-1] | (BLOCK << base);
                end
                if (LAST && !valid_pipe[gi-1]) begin
                    word_next = '0;
                end
            end

            // Stage register for the partial word and valid bit.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    word_reg  <= '0;
                    valid_reg <= 1'b0;
                end else if (bus.enable) begin
                    word_reg  <= word_next;
                    valid_reg <= valid_pipe[gi-1];
                end
            end

            assign word_pipe[gi]  = word_reg;
            assign valid_pipe[gi] = valid_reg;

            if (!LAST) begin : g_code
                logic [b-1:0] code_reg;

                // Forward the code to the next stage.
                // Its upper bits locate the fill and its low bits are still unresolved.
                always_ff @(posedge clock or negedge reset_n) begin
                    if (!reset_n) begin
                        code_reg <= '0;
                    end else if (bus.enable) begin
                        code_reg <= code_pipe[gi-1];
                    end
                end

                assign code_pipe[gi] = code_reg;
            end
        end
    endgenerate

    assign bus.valid_out = valid_pipe[b];
    assign bus.thermo    = word_pipe[b];
endmodule

// File: doc/bin2therm_pipeline.md
# bin2therm_pipeline

Pipelined binary-to-thermometer encoder for the ADC datapath, the inverse of the thermometer-to-binary decoder. It takes a `b`-bit code with a qualifier and produces the `2**b`-bit thermometer word in the same bit layout the decoder consumes, so the two blocks can sit back to back. It drives unary DAC/reference segment selects and serves as the stimulus source for decoder round-trip checks. The block resolves one binary bit per pipeline stage, MSB first, at one sample per clock.

## Interface
- `b`, default 8, code width in bits; legal range 2..10.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  pipeline advance; low freezes every stage.
- `valid`  in  1  `bin` qualifier, sampled when `enable` is 1.
- `bin`  in  `b`  binary code, unsigned.
- `valid_out`  out  1  `thermo` carries a real sample.
- `thermo`  out  `2**b`  thermometer word; bit `j` = 1 iff `j < code`.

## Operation
- Reset is asynchronous and active-low. While `reset_n` = 0, every stage register, every valid bit, `valid_out` and `thermo` are 0.
- Pipeline structure: one input register (stage 0), then `b` resolve stages (stages 1..`b`). Stage `b` is the output register.
- Stage `k` (1..`b`) handles bit `b-k` of the carried code:
  - If the bit is 1, it fills `2**(b-k)` ones directly above the already-filled region.
  - It forwards the remaining LSBs and the partial word to the next stage.
  - It forwards the stage valid bit.
- Output encoding:
  - `thermo[2**b-1]` is always 0.
  - Code `2**b-1` sets bits `2**b-2..0`.
  - Code 0 gives all zeros.
- Invalid samples: a stage entry with valid = 0 still propagates. The output register loads `thermo` = 0 and `valid_out` = 0 for it. There are no stale words at the output.
- `enable` = 0:
  - All stages, including the output register, hold their contents.
  - `valid` and `bin` are ignored.
  - `valid_out` and `thermo` stay constant.
- No backpressure beyond `enable`. Throughput is one sample per enabled cycle.
- Arithmetic: `bin` is unsigned. No out-of-range codes exist for `b` bits. Partial words never exceed `2**b-1` ones.

## Timing
- Latency is `b+1` enabled edges.
  - A sample captured at enabled edge `t` appears on `valid_out` and `thermo` immediately after enabled edge `t+b`.
  - For `b` = 8, that is 9 registers.
- Edges with `enable` = 0 do not count toward latency. In-flight samples are neither lost nor duplicated across a stall.
- Back-to-back valid samples emerge on consecutive enabled cycles, in order.
- Reset asserted mid-operation:
  - All in-flight samples are discarded immediately, without waiting for a clock.
  - After `reset_n` rises, the first `valid_out` = 1 comes `b+1` enabled edges after the first valid capture.
- `valid` and `enable` are both sampled on the rising edge. No combinational path runs from the inputs to the outputs.
- `thermo` and `valid_out` change only on a rising edge or on reset assertion.

## Test plan
- Reset:
  - Assert `reset_n` = 0 with the pipeline full of `bin` = 8'hFF samples.
  - Required: `valid_out` = 0 and `thermo` = 0 immediately.
  - After release, they stay 0 until 9 edges after the first valid capture.
- Endpoints, `b` = 8:
  - `bin` = 0 gives `thermo` = 0.
  - `bin` = 1 gives only bit 0 set.
  - `bin` = 128 gives bits 127..0 set.
  - `bin` = 255 gives bits 254..0 set and bit 255 = 0.
  - Each appears with `valid_out` = 1 exactly 9 edges after capture.
- Ramp:
  - Drive `bin` = 0..255 on consecutive cycles with `valid` = 1 and `enable` = 1.
  - Required: 256 consecutive outputs, each with popcount equal to its code, in order, with no gaps.
- Stall:
  - Insert `enable` = 0 for 5 cycles in the middle of the ramp.
  - Required: outputs frozen for 5 cycles, then the sequence resumes with no loss or duplication. Total latency is 9 plus 5 cycles.
- Invalid bubbles:
  - Alternate `valid` 1/0 with `bin` = 8'hAA throughout.
  - Required: output alternates between 170 ones with `valid_out` = 1 and all zeros with `valid_out` = 0.
- Round trip:
  - Connect the output to the thermometer-to-binary decoder (`b` = 8) and drive random codes.
  - Required: the decoded `bin` equals the input code for every valid sample.
